// File: rtl/regbus_pkg.sv
// Shared definitions for the peripheral register-bus arbiter: sequencer states,
// register map addresses and the fixed identification values.
package regbus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [2:0] CNAME    = 3'd0;
   localparam logic [2:0] CVERSION = 3'd1;
   localparam logic [2:0] TRISTATE = 3'd2;
   localparam logic [2:0] PINSTATE = 3'd3;
   localparam logic [2:0] INTMASK  = 3'd4;
   localparam logic [2:0] DATAREG  = 3'd5;
   localparam logic [2:0] SCRATCH  = 3'd6;

   localparam logic [31:0] CNAME_VAL    = 32'h48524a44;
   localparam logic [31:0] CVERSION_VAL = 32'h00000001;

   // Reads must never carry byte enables onto the register file pins.
   function automatic logic [3:0] issue_wben(input logic we, input logic [3:0] wben);
      logic [3:0] result;
      if (we) begin
         result = wben;
      end else begin
         result = 4'b0000;
      end
      return result;
   endfunction

endpackage

// File: rtl/regbus_arbiter_rr_arb2.sv
// Two-input round-robin picker; the caller owns the last_grant flop.
module rr_arb2
   import regbus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       winner,
   output logic       valid
);

   // Lone requester wins outright; contention goes to the one not served last.
   always_comb begin
      valid  = |req;
      winner = last_grant;
      case (req)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last_grant;
         default: winner = last_grant;
      endcase
   end

endmodule

// File: rtl/regbus_arbiter.sv
// Round-robin arbiter and IDLE/ISSUE/RESP/DONE sequencer between two requesters
// and the single-port peripheral register file.
module regbus_arbiter
   import regbus_pkg::*;
#(
   parameter int ADDR_W      = 3,
   parameter int DATA_W      = 32,
   parameter int FIRST_GRANT = 0
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [3:0]        m0_wben,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [3:0]        m1_wben,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [3:0]        rf_wben,
   output logic              rf_r_wn,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [DATA_W-1:0] rf_rdata
);

   localparam logic LAST_GRANT_RST = (FIRST_GRANT == 0) ? 1'b1 : 1'b0;

   state_t            state_r;
   logic              grant_r;
   logic              last_grant_r;
   logic              we_r;
   logic              rr_winner_s;
   logic              rr_valid_s;
   logic              sel_we_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [3:0]        sel_wben_s;
   logic [DATA_W-1:0] sel_wdata_s;

   rr_arb2 u_rr_arb2 (
      .req        ({m1_req, m0_req}),
      .last_grant (last_grant_r),
      .winner     (rr_winner_s),
      .valid      (rr_valid_s)
   );

   // Route the winning requester's transaction fields; the loser never reaches rf_*.
   always_comb begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wben_s  = m0_wben;
      sel_wdata_s = m0_wdata;
      if (rr_winner_s) begin
         sel_we_s    = m1_we;
         sel_addr_s  = m1_addr;
         sel_wben_s  = m1_wben;
         sel_wdata_s = m1_wdata;
      end else begin
         sel_we_s    = m0_we;
         sel_addr_s  = m0_addr;
         sel_wben_s  = m0_wben;
         sel_wdata_s = m0_wdata;
      end
   end

   // Sequencer: r_wn is low for exactly the ISSUE cycle of a write, since the
   // register file writes on every cycle it sees r_wn=0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         grant_r      <= 1'b0;
         last_grant_r <= LAST_GRANT_RST;
         we_r         <= 1'b0;
         rf_addr      <= '0;
         rf_wben      <= 4'b0000;
         rf_r_wn      <= 1'b1;
         rf_wdata     <= '0;
         m0_ack       <= 1'b0;
         m1_ack       <= 1'b0;
         m0_rdata     <= '0;
         m1_rdata     <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (rr_valid_s) begin
                  grant_r      <= rr_winner_s;
                  last_grant_r <= rr_winner_s;
                  we_r         <= sel_we_s;
                  rf_addr      <= sel_addr_s;
                  rf_wben      <= issue_wben(sel_we_s, sel_wben_s);
                  rf_wdata     <= sel_wdata_s;
                  rf_r_wn      <= ~sel_we_s;
                  state_r      <= ISSUE;
               end else begin
                  state_r      <= IDLE;
               end
            end
            ISSUE: begin
               rf_r_wn <= 1'b1;
               rf_wben <= 4'b0000;
               state_r <= RESP;
            end
            RESP: begin
               // rf_rdata reflects the address sampled at the end of ISSUE.
               if (grant_r) begin
                  m1_ack <= 1'b1;
                  if (!we_r) begin
                     m1_rdata <= rf_rdata;
                  end else begin
                     m1_rdata <= m1_rdata;
                  end
               end else begin
                  m0_ack <= 1'b1;
                  if (!we_r) begin
                     m0_rdata <= rf_rdata;
                  end else begin
                     m0_rdata <= m0_rdata;
                  end
               end
               state_r <= DONE;
            end
            DONE: begin
               m0_ack  <= 1'b0;
               m1_ack  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               rf_r_wn <= 1'b1;
               rf_wben <= 4'b0000;
               m0_ack  <= 1'b0;
               m1_ack  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regbus_arbiter.sv
// Bench for regbus_arbiter: register-file model, directed vector table, hand
// sequences for idle/reset corners, and randomized rounds against a scoreboard.
module tb_regbus_arbiter;
   import regbus_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [2:0]  m0_addr, m1_addr;
   logic [3:0]  m0_wben, m1_wben;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic [2:0]  rf_addr;
   logic [3:0]  rf_wben;
   logic        rf_r_wn;
   logic [31:0] rf_wdata;
   logic [31:0] rf_rdata;
   logic [15:0] pins = 16'hA5A5;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] rf_mem [8];
   logic [31:0] exp_mem [8];
   logic [31:0] prev_rd [2];
   logic        model_last;

   always #5 clk = ~clk;

   regbus_arbiter #(.ADDR_W(3), .DATA_W(32), .FIRST_GRANT(0)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wben(m0_wben),
      .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wben(m1_wben),
      .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .rf_addr(rf_addr), .rf_wben(rf_wben), .rf_r_wn(rf_r_wn),
      .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
   );

   function automatic logic [31:0] reg_view(input logic [2:0] a, input logic [31:0] stored);
      case (a)
         CNAME:    return CNAME_VAL;
         CVERSION: return CVERSION_VAL;
         PINSTATE: return {16'h0000, pins};
         3'd7:     return 32'h0;
         default:  return stored;
      endcase
   endfunction

   function automatic logic [31:0] apply_wr(input logic [2:0] a, input logic [31:0] old,
                                            input logic [3:0] be, input logic [31:0] d);
      logic [31:0] n = old;
      case (a)
         TRISTATE, INTMASK, DATAREG: begin
            if (be[0]) n[7:0]  = d[7:0];
            if (be[1]) n[15:8] = d[15:8];
            n[31:16] = 16'h0000;
         end
         SCRATCH: for (int i = 0; i < 4; i++) if (be[i]) n[i*8 +: 8] = d[i*8 +: 8];
         default: n = old;
      endcase
      return n;
   endfunction

   // Register file: writes whenever r_wn=0, registered read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) rf_mem[i] <= 32'h0;
         rf_rdata <= 32'h0;
      end else begin
         rf_rdata <= reg_view(rf_addr, rf_mem[rf_addr]);
         if (!rf_r_wn) rf_mem[rf_addr] <= apply_wr(rf_addr, rf_mem[rf_addr], rf_wben, rf_wdata);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) exp_mem[i] = 32'h0;
      prev_rd[0] = 32'h0;
      prev_rd[1] = 32'h0;
      model_last = 1'b1;
   endtask

   task automatic idle_inputs();
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = 3'd0; m0_wben = 4'h0; m0_wdata = 32'h0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 3'd0; m1_wben = 4'h0; m1_wdata = 32'h0;
   endtask

   // One arbitration round: requests raised together, held until acked.
   task automatic run_round(input int id,
      input logic r0, input logic we0, input logic [2:0] a0, input logic [3:0] b0, input logic [31:0] d0,
      input logic r1, input logic we1, input logic [2:0] a1, input logic [3:0] b1, input logic [31:0] d1,
      input logic exp_first, input logic [31:0] er0, input logic [31:0] er1);
      int          ack_cyc [2];
      logic        we_a [2];
      logic [2:0]  ad_a [2];
      logic [3:0]  be_a [2];
      logic [31:0] d_a [2];
      logic [31:0] er_a [2];
      logic        issuing;
      int          ncyc;
      ack_cyc[0] = -1; ack_cyc[1] = -1;
      we_a[0] = we0; ad_a[0] = a0; be_a[0] = b0; d_a[0] = d0; er_a[0] = er0;
      we_a[1] = we1; ad_a[1] = a1; be_a[1] = b1; d_a[1] = d1; er_a[1] = er1;
      if (r0 && r1) begin
         ack_cyc[exp_first]  = 3;
         ack_cyc[!exp_first] = 7;
         model_last = !exp_first;
      end else if (r0) begin
         ack_cyc[0] = 3; model_last = 1'b0;
      end else begin
         ack_cyc[1] = 3; model_last = 1'b1;
      end
      ncyc = (r0 && r1) ? 9 : 5;
      m0_req = r0; m0_we = we0; m0_addr = a0; m0_wben = b0; m0_wdata = d0;
      m1_req = r1; m1_we = we1; m1_addr = a1; m1_wben = b1; m1_wdata = d1;
      for (int cyc = 1; cyc <= ncyc; cyc++) begin
         @(posedge clk); #1;
         issuing = 1'b0;
         for (int m = 0; m < 2; m++) begin
            chk($sformatf("r%0d m%0d_ack c%0d", id, m, cyc), (m == 0) ? m0_ack : m1_ack,
                (cyc == ack_cyc[m]) ? 32'd1 : 32'd0);
            if (ack_cyc[m] > 0 && cyc == ack_cyc[m] - 2) begin
               issuing = 1'b1;
               chk($sformatf("r%0d m%0d rf_r_wn", id, m), rf_r_wn, we_a[m] ? 32'd0 : 32'd1);
               chk($sformatf("r%0d m%0d rf_addr", id, m), rf_addr, ad_a[m]);
               chk($sformatf("r%0d m%0d rf_wben", id, m), rf_wben, we_a[m] ? be_a[m] : 4'h0);
               if (we_a[m]) chk($sformatf("r%0d m%0d rf_wdata", id, m), rf_wdata, d_a[m]);
            end
            if (cyc == ack_cyc[m]) begin
               if (!we_a[m]) prev_rd[m] = er_a[m];
               chk($sformatf("r%0d m%0d_rdata", id, m), (m == 0) ? m0_rdata : m1_rdata, prev_rd[m]);
               if (we_a[m]) exp_mem[ad_a[m]] = apply_wr(ad_a[m], exp_mem[ad_a[m]], be_a[m], d_a[m]);
               if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
            end
         end
         if (!issuing) chk($sformatf("r%0d idle r_wn/wben c%0d", id, cyc), {rf_r_wn, rf_wben}, 5'b10000);
      end
      idle_inputs();
   endtask

   typedef struct {
      logic        r0, we0;
      logic [2:0]  a0;
      logic [3:0]  b0;
      logic [31:0] d0;
      logic        r1, we1;
      logic [2:0]  a1;
      logic [3:0]  b1;
      logic [31:0] d1;
      logic        first;
      logic [31:0] rd0, rd1;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic        pr [2];
      logic        rwe [2];
      logic [2:0]  ra [2];
      logic [3:0]  rb [2];
      logic [31:0] rdv [2];
      logic [31:0] rer [2];
      logic [31:0] tmp [8];
      logic [1:0]  pat;
      logic        f;
      int          o;

      tbl[0]  = '{1'b1, 1'b0, CNAME,    4'h0, 32'h0,          1'b0, 1'b0, 3'd0,    4'h0, 32'h0,        1'b0, CNAME_VAL,    32'h0};
      tbl[1]  = '{1'b0, 1'b0, 3'd0,     4'h0, 32'h0,          1'b1, 1'b1, SCRATCH, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0,      32'h0};
      tbl[2]  = '{1'b0, 1'b0, 3'd0,     4'h0, 32'h0,          1'b1, 1'b0, SCRATCH, 4'h0, 32'h0,        1'b1, 32'h0,      32'hDEADBEEF};
      tbl[3]  = '{1'b1, 1'b0, CVERSION, 4'h0, 32'h0,          1'b1, 1'b0, PINSTATE, 4'h0, 32'h0,       1'b0, 32'h00000001, 32'h0000A5A5};
      tbl[4]  = tbl[3];
      tbl[5]  = tbl[3];
      tbl[6]  = '{1'b1, 1'b1, DATAREG,  4'h3, 32'h00003400,   1'b0, 1'b0, 3'd0,    4'h0, 32'h0,        1'b0, 32'h0,      32'h0};
      tbl[7]  = '{1'b1, 1'b1, DATAREG,  4'h1, 32'h000012FF,   1'b0, 1'b0, 3'd0,    4'h0, 32'h0,        1'b0, 32'h0,      32'h0};
      tbl[8]  = '{1'b1, 1'b0, DATAREG,  4'h0, 32'h0,          1'b0, 1'b0, 3'd0,    4'h0, 32'h0,        1'b0, 32'h000034FF, 32'h0};
      tbl[9]  = '{1'b1, 1'b1, SCRATCH,  4'hF, 32'h11223344,   1'b0, 1'b0, 3'd0,    4'h0, 32'h0,        1'b0, 32'h0,      32'h0};
      tbl[10] = '{1'b1, 1'b0, SCRATCH,  4'h0, 32'h0,          1'b1, 1'b0, CVERSION, 4'h0, 32'h0,       1'b1, 32'h11223344, 32'h00000001};

      idle_inputs();
      reset = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset rf_r_wn", rf_r_wn, 32'd1);
      chk("reset rf_addr/wben", {rf_addr, rf_wben}, 32'd0);
      chk("reset rf_wdata", rf_wdata, 32'd0);
      chk("reset acks", {m0_ack, m1_ack}, 32'd0);
      chk("reset m0_rdata", m0_rdata, 32'd0);
      chk("reset m1_rdata", m1_rdata, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++)
         run_round(i, tbl[i].r0, tbl[i].we0, tbl[i].a0, tbl[i].b0, tbl[i].d0,
                   tbl[i].r1, tbl[i].we1, tbl[i].a1, tbl[i].b1, tbl[i].d1,
                   tbl[i].first, tbl[i].rd0, tbl[i].rd1);

      // Twenty idle cycles: the register file must never see a write strobe.
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         chk($sformatf("idle r_wn/wben c%0d", c), {rf_r_wn, rf_wben}, 5'b10000);
         chk($sformatf("idle acks c%0d", c), {m0_ack, m1_ack}, 32'd0);
      end
      run_round(100, 1'b1, 1'b0, SCRATCH, 4'h0, 32'h0, 1'b0, 1'b0, 3'd0, 4'h0, 32'h0,
                1'b0, 32'h11223344, 32'h0);

      // Reset lands during the RESP cycle of an m1 write.
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = SCRATCH; m1_wben = 4'hF; m1_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      chk("rst-seq issue r_wn", rf_r_wn, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst-seq m1_ack", m1_ack, 32'd0);
      chk("rst-seq rf_r_wn", rf_r_wn, 32'd1);
      chk("rst-seq rf_addr/wben", {rf_addr, rf_wben}, 32'd0);
      chk("rst-seq rf_wdata", rf_wdata, 32'd0);
      chk("rst-seq m0_rdata", m0_rdata, 32'd0);
      chk("rst-seq m1_rdata", m1_rdata, 32'd0);
      reset = 1'b0;
      idle_inputs();
      model_reset();
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("rst-seq no ack c%0d", c), {m0_ack, m1_ack}, 32'd0);
      end
      run_round(200, 1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 1'b0, SCRATCH, 4'h0, 32'h0,
                1'b1, 32'h0, 32'h0);

      // Randomized rounds; expectations come from the scoreboard memory.
      for (int k = 0; k < 40; k++) begin
         pat = 2'($urandom_range(1, 3));
         for (int m = 0; m < 2; m++) begin
            pr[m]  = pat[m];
            rwe[m] = 1'($urandom_range(0, 1));
            ra[m]  = 3'($urandom_range(0, 7));
            rb[m]  = 4'($urandom_range(0, 15));
            rdv[m] = $urandom;
            rer[m] = 32'h0;
         end
         f = (pr[0] && pr[1]) ? !model_last : !pr[0];
         for (int i = 0; i < 8; i++) tmp[i] = exp_mem[i];
         for (int s = 0; s < 2; s++) begin
            o = (s == 0) ? int'(f) : int'(!f);
            if (pr[o]) begin
               rer[o] = reg_view(ra[o], tmp[ra[o]]);
               if (rwe[o]) tmp[ra[o]] = apply_wr(ra[o], tmp[ra[o]], rb[o], rdv[o]);
            end
         end
         run_round(300 + k, pr[0], rwe[0], ra[0], rb[0], rdv[0],
                   pr[1], rwe[1], ra[1], rb[1], rdv[1], f, rer[0], rer[1]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/regbus_arbiter.md
Name: regbus_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port memory-mapped peripheral register file (chip name/version, GPIO tristate/datareg/interrupt-mask, scratch).
- Requester 0 is the CPU core load/store unit; requester 1 is the debug/UART loader.
- Grants round-robin and drives the register file's addr/wben/r_wn/wdata pins.
- Captures the one-cycle-late registered rdata and returns it to the granted requester with an ack pulse.

Parameters:
- ADDR_W, 3, register word-address width (addresses 8 x 32-bit registers).
- DATA_W, 32, data width.
- FIRST_GRANT, 0, requester that wins the first contested arbitration after reset.

Ports:
- clk  in  1  master clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  requester 0 transaction request, held until m0_ack
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  register word address
- m0_wben  in  4  write byte enables
- m0_wdata  in  DATA_W  write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  read data, valid while m0_ack=1
- m1_req, m1_we, m1_addr, m1_wben, m1_wdata, m1_ack, m1_rdata: same as m0_*, for requester 1
- rf_addr  out  ADDR_W  to register file addr
- rf_wben  out  4  to register file wben
- rf_r_wn  out  1  to register file r_wn (1 = read)
- rf_wdata  out  DATA_W  to register file wdata
- rf_rdata  in  DATA_W  from register file rdata (registered there, valid one cycle after sampling)

Behaviour:
- Reset values (all outputs registered):
  - rf_r_wn=1; rf_addr=0; rf_wben=0; rf_wdata=0.
  - m0_ack=m1_ack=0; m0_rdata=m1_rdata=0.
  - state=IDLE; last_grant=~FIRST_GRANT.
- Idle safety: whenever no write is being issued, rf_r_wn=1 and rf_wben=0. The register file writes on every cycle with r_wn=0, so r_wn=0 is driven only in ISSUE for a write.
- IDLE:
  - If either req=1, pick a winner. If only one requests, it wins. If both request, the winner is the one != last_grant.
  - Register grant=winner and last_grant=winner.
  - Load rf_addr, rf_wben (forced to 0 on reads), rf_wdata, and rf_r_wn=~we from the winner. Go to ISSUE.
- ISSUE (1 cycle):
  - Register file samples the rf_* pins at this cycle's closing edge.
  - On this same edge, rf_r_wn←1 and rf_wben←0. Go to RESP.
- RESP (1 cycle):
  - rf_rdata is now valid. At the closing edge, m{grant}_rdata←rf_rdata, but only for reads; write rdata keeps its previous value.
  - m{grant}_ack←1 and state←DONE.
- DONE (1 cycle):
  - m{grant}_ack is high this cycle; the requester samples rdata here.
  - Acks clear at the closing edge; state←IDLE.
  - The requester must drop req in the cycle after ack or present a new transaction.
- Latency: req seen in IDLE at cycle T → rf pins driven at T+1 → ack high at T+3. Reads and writes have identical latency. Max throughput is one transaction per 4 cycles.
- Arbitration reads req only in IDLE. A req arriving mid-transaction waits. A req withdrawn before grant is simply ignored.
- Fairness: with both requesters continuously requesting, grants strictly alternate.
- Simultaneous events: both req in IDLE resolves by round-robin. The losing requester's inputs are ignored and never touch rf_*.
- Reset mid-transaction: immediate return to the reset values at the reset edge. No ack is issued. A write already sampled by the register file stands; the register file clears its own contents on the shared reset anyway.
- Address/width: addr is passed through unmodified. wben is passed through on writes; the register file ignores upper bytes for 16-bit registers and ignores writes to read-only addresses.

Decomposition:
- Shared package regbus_pkg holds:
  - state encoding (IDLE, ISSUE, RESP, DONE);
  - register address constants (CNAME=0, CVERSION=1, TRISTATE=2, PINSTATE=3, INTMASK=4, DATAREG=5, SCRATCH=6);
  - CNAME_VAL=32'h48524a44, CVERSION_VAL=32'h00000001.
- One optional sub-module rr_arb2: a 2-input round-robin picker (req[1:0], last_grant → winner). It is combinational plus the caller's last_grant flop.

Test Plan:
- Reset, then m0 read addr 0 → rf_r_wn=1 throughout, m0_ack exactly at T+3, m0_rdata=32'h48524a44. m1_ack never rises.
- m1 write addr 6, wben 4'hF, data 32'hDEADBEEF, then m1 read addr 6 → rf_r_wn=0 only during the ISSUE cycle. Readback 32'hDEADBEEF.
- m0 and m1 both request every cycle for 6 transactions (m0 reads addr 1, m1 reads addr 3 with pinstate 16'hA5A5) → grant order 0,1,0,1,0,1. rdata 32'h00000001 and 32'h0000A5A5 respectively.
- m0 write addr 5, wben 4'b0001, data 32'h0000_12FF after datareg=16'h3400 → read addr 5 returns 32'h000034FF.
- m1 write addr 6 with reset asserted during the RESP cycle → no m1_ack. All outputs return to reset values next cycle. Subsequent read of addr 6 returns 0.
- Idle 20 cycles with no req → rf_r_wn=1 and rf_wben=0 every cycle. Scratch preloaded with 32'h11223344 is unchanged.
